uart_frame_tx: RTL and testbench
================================

# uart_frame_tx

Parametrised, trigger-started UART frame transmitter. One accepted trigger captures a `DATA_BYTES`-byte word and serialises it as back-to-back UART characters. Each character has a start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits, at `CLKS_PER_BIT` clocks per bit. It drives the board TX pin directly and reports `busy` and `done` to the controlling logic.

## Interface
- `CLKS_PER_BIT`, default 50: clocks per bit time; legal range ≥ 2.
- `DATA_BYTES`, default 2: characters per frame; legal range ≥ 1.
- `PARITY`, default 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: stop bits per character; legal values 1 or 2.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `trig`, input, 1: frame request. Sampled every clock.
- `tx_data`, input, `8*DATA_BYTES`: frame payload. Byte 0 is `tx_data[7:0]` and is sent first.
- `tx_out`, output, 1: serial line. Idles high.
- `busy`, output, 1: high while a frame is in progress.
- `done`, output, 1: one-cycle pulse when a frame completes.

## Operation
- Reset values: `tx_out`=1, `busy`=0, `done`=0, state=IDLE, all counters 0.
- States: IDLE → START → DATA → (PARITY if `PARITY`≠0) → STOP → START of the next byte, or IDLE after the last byte.
- IDLE:
  - `tx_out`=1.
  - On `trig`=1, latch `tx_data` into a shift/hold register, clear the byte index, and go to START.
- START: `tx_out`=0 for one bit time.
- DATA:
  - Send bits 0..7 of the current byte, LSB first.
  - A 3-bit bit index counts 0..7.
- PARITY:
  - Even mode: `tx_out` = XOR of the 8 data bits.
  - Odd mode: `tx_out` = XNOR of the 8 data bits.
  - Lasts one bit time.
- STOP: `tx_out`=1 for `STOP_BITS` bit times.
- At the end of STOP:
  - If byte index < `DATA_BYTES`-1, increment it and go to START. There is no idle gap between characters.
  - Otherwise go to IDLE.
- `busy` is high in every state except IDLE.
- `done`=1 for exactly the first IDLE cycle after the final stop bit.
- `trig` while `busy`=1 is ignored. It does not toggle, abort or queue. `tx_data` changes after capture have no effect on the frame in flight.
- `trig`=1 in the `done` cycle is accepted. This gives back-to-back frames with one idle-high cycle between them.
- Bit-time counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at the end of each bit.
  - All state and bit advances happen on the wrap.
- Byte index width: `$clog2(DATA_BYTES)`, with a minimum of 1 bit.
- Reset mid-frame: outputs return to their reset values immediately (asynchronously) and the frame is discarded. There is no partial completion and no `done` pulse.

## Timing
- `trig` is sampled high at rising edge k in IDLE:
  - `busy`=1 and `tx_out`=0 take effect from edge k, visible the cycle after the trigger cycle.
  - Start bit covers cycles k..k+`CLKS_PER_BIT`-1.
- Bits per character: B = 10 + (`PARITY`≠0) + (`STOP_BITS`-1).
- Frame length: `DATA_BYTES`·B·`CLKS_PER_BIT` cycles with `busy`=1.
- `done` is asserted at edge k + frame length, the same edge at which `busy` falls.
- All outputs are registered. There is no combinational path from `trig` or `tx_data` to any output.

## Test plan
- **Reset.**
  - Stimulus: assert `rst` mid-frame (`tx_out`=0 at the time).
  - Required: `tx_out`=1, `busy`=0, `done`=0 within the same cycle. After release, the line stays idle until a new `trig`.
- **Default configuration** (CPB=50, BYTES=2, no parity, 1 stop).
  - Stimulus: `tx_data`=16'hA53C with one `trig`.
  - Required: the line carries 0,0011 1100 LSB-first,1 then 0,1010 0101 LSB-first,1.
  - Required: each bit lasts exactly 50 cycles, `busy` lasts 1000 cycles, and there is a single `done` pulse.
- **Parity.**
  - Stimulus: BYTES=1, `tx_data`=8'h07, first with PARITY=1, then with PARITY=2.
  - Required: parity bit is 1 for even and 0 for odd. Frame is 11 bit times.
- **Two stop bits.**
  - Stimulus: STOP_BITS=2, BYTES=3, CPB=4, data 24'hFF0080.
  - Required: the line is high for 8 cycles between characters. Total `busy` = 3·11·4 = 132 cycles.
- **Trigger rules.**
  - Stimulus: pulse `trig` repeatedly during a frame and change `tx_data` mid-frame.
  - Required: the frame is unchanged and has the original length, with no extra frames.
  - Stimulus: `trig`=1 in the `done` cycle.
  - Required: the next start bit begins one cycle after `busy` falls.
- **Minimum divider.**
  - Stimulus: CPB=2, BYTES=1, data 8'h55.
  - Required: bits alternate every 2 cycles and the bit-time counter wraps correctly with no off-by-one.

Source files
------------

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - trigger-started multi-byte UART frame transmitter
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 50,
    parameter int DATA_BYTES   = 2,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trig,
    input  logic [8*DATA_BYTES-1:0] tx_data,
    output logic                    tx_out,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           clk_cnt_q, clk_cnt_d;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic [BW-1:0]           byte_idx_q, byte_idx_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic [8*DATA_BYTES-1:0] hold_q, hold_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    wrap;
    logic                    last_byte;
    logic [7:0]              cur_byte;

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        stop_cnt_d = stop_cnt_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        wrap       = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
        last_byte  = (32'(byte_idx_q) == 32'(DATA_BYTES - 1));

        if (state_q != S_IDLE) begin
            clk_cnt_d = wrap ? '0 : clk_cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (trig) begin
                    hold_d     = tx_data;
                    byte_idx_d = '0;
                    bit_idx_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (wrap) begin
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (wrap) begin
                    if (bit_idx_q == 3'd7) begin
                        stop_cnt_d = 1'b0;
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (wrap) begin
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (wrap) begin
                    if (STOP_BITS == 2 && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (!last_byte) begin
                        byte_idx_d = byte_idx_q + BW'(1);
                        state_d    = S_START;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is computed from the next state so every output stays registered.
        cur_byte = hold_d[7:0];
        for (int i = 1; i < DATA_BYTES; i++) begin
            if (32'(byte_idx_d) == 32'(i)) begin
                cur_byte = hold_d[i*8 +: 8];
            end
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = cur_byte[bit_idx_d];
            S_PARITY: tx_d = (PARITY == 2) ? ~^cur_byte : ^cur_byte;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= '0;
            stop_cnt_q <= 1'b0;
            hold_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            stop_cnt_q <= stop_cnt_d;
            hold_q     <= hold_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - directed bench for uart_frame_tx across several configurations
module tb_uart_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  trig;
    logic [15:0] d0;
    logic [7:0]  d1, d2, d4;
    logic [23:0] d3;
    logic [4:0]  tx_o, busy_o, done_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // 0: defaults; 1: even parity; 2: odd parity; 3: two stop bits; 4: minimum divider
    uart_frame_tx u0 (.clk(clk), .rst(rst), .trig(trig[0]), .tx_data(d0),
                      .tx_out(tx_o[0]), .busy(busy_o[0]), .done(done_o[0]));
    uart_frame_tx #(.CLKS_PER_BIT(4), .DATA_BYTES(1), .PARITY(1)) u1 (
        .clk(clk), .rst(rst), .trig(trig[1]), .tx_data(d1),
        .tx_out(tx_o[1]), .busy(busy_o[1]), .done(done_o[1]));
    uart_frame_tx #(.CLKS_PER_BIT(4), .DATA_BYTES(1), .PARITY(2)) u2 (
        .clk(clk), .rst(rst), .trig(trig[2]), .tx_data(d2),
        .tx_out(tx_o[2]), .busy(busy_o[2]), .done(done_o[2]));
    uart_frame_tx #(.CLKS_PER_BIT(4), .DATA_BYTES(3), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .trig(trig[3]), .tx_data(d3),
        .tx_out(tx_o[3]), .busy(busy_o[3]), .done(done_o[3]));
    uart_frame_tx #(.CLKS_PER_BIT(2), .DATA_BYTES(1)) u4 (
        .clk(clk), .rst(rst), .trig(trig[4]), .tx_data(d4),
        .tx_out(tx_o[4]), .busy(busy_o[4]), .done(done_o[4]));

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic start(input int sel);
        @(negedge clk);
        trig[sel] = 1'b1;
        @(negedge clk);
        trig[sel] = 1'b0;
    endtask

    // Entered in the first cycle after the accepting edge; exp lists line bits in send order.
    task automatic run_frame(input int sel, input string exp, input int cpb,
                             input bit noise, input bit chain);
        int n;
        n = exp.len() * cpb;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("tx u%0d cyc%0d", sel, i), tx_o[sel], exp.getc(i / cpb) == 8'h31);
            chk($sformatf("busy u%0d cyc%0d", sel, i), busy_o[sel], 1'b1);
            chk($sformatf("done u%0d cyc%0d", sel, i), done_o[sel], 1'b0);
            if (noise) begin
                trig[sel] = 1'($urandom);
                d3 = 24'($urandom);
            end
            @(negedge clk);
        end
        chk($sformatf("done_pulse u%0d", sel), done_o[sel], 1'b1);
        chk($sformatf("busy_fall u%0d", sel), busy_o[sel], 1'b0);
        chk($sformatf("tx_idle_done u%0d", sel), tx_o[sel], 1'b1);
        trig[sel] = chain;
        @(negedge clk);
        trig[sel] = 1'b0;
        if (!chain) begin
            for (int i = 0; i < 3 * cpb; i++) begin
                chk($sformatf("idle_tx u%0d cyc%0d", sel, i), tx_o[sel], 1'b1);
                chk($sformatf("idle_busy u%0d cyc%0d", sel, i), busy_o[sel], 1'b0);
                chk($sformatf("idle_done u%0d cyc%0d", sel, i), done_o[sel], 1'b0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        trig = '0;
        d0   = 16'hA53C;
        d1   = 8'h07;
        d2   = 8'h07;
        d3   = 24'hFF0080;
        d4   = 8'h55;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx_o[0], 1'b1);
        chk("reset_busy", busy_o[0], 1'b0);
        chk("reset_done", done_o[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);

        start(0);
        run_frame(0, "00011110010101001011", 50, 1'b0, 1'b0);

        start(1);
        run_frame(1, "01110000011", 4, 1'b0, 1'b1);
        run_frame(1, "01110000011", 4, 1'b0, 1'b0);

        start(2);
        run_frame(2, "01110000001", 4, 1'b0, 1'b0);

        start(3);
        run_frame(3, "000000001110000000001101111111111", 4, 1'b1, 1'b0);
        d3 = 24'hFF0080;
        start(3);
        run_frame(3, "000000001110000000001101111111111", 4, 1'b0, 1'b0);

        start(4);
        run_frame(4, "0101010101", 2, 1'b0, 1'b0);

        start(0);
        repeat (10) @(negedge clk);
        chk("pre_rst_tx", tx_o[0], 1'b0);
        chk("pre_rst_busy", busy_o[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_tx", tx_o[0], 1'b1);
        chk("async_rst_busy", busy_o[0], 1'b0);
        chk("async_rst_done", done_o[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_tx cyc%0d", i), tx_o[0], 1'b1);
            chk($sformatf("post_rst_busy cyc%0d", i), busy_o[0], 1'b0);
            chk($sformatf("post_rst_done cyc%0d", i), done_o[0], 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
